hv_core_param: RTL
==================

// Module: hv_core_param
// PURPOSE
//  Parametrised hypervector compute core: item memory, bind (XOR), permute (rotate), store/last output.
//  Item memory is filled from a WORD-wide random stream. A 16-bit instruction stream drives the core.
//  Results leave through a valid/ready port with backpressure.
//  Sits between the instruction/random DMA front end and the result collector; one instance per thread.
// PARAMETERS
//  DIM      1024           hypervector width in bits; multiple of WORD; 2..4096
//  WORD     32             random-fill word width; DIM/WORD words form one vector
//  DEPTH    512            item memory entries; power of 2
//  AW       $clog2(DEPTH)  item address width (derived)
//  SW       $clog2(DIM)    rotate amount width (derived)
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst         in   1      reset, synchronous, active-high
//  fill_en     in   1      fill mode; 0 clears fill counters and discards any partial vector
//  fill_valid  in   1      fill word valid
//  fill_ready  out  1      fill word ready (= fill_en & ~rst)
//  fill_data   in   WORD   fill word; word j lands at bits [j*WORD +: WORD]
//  fill_count  out  AW+1   vectors written since fill_en rose, saturates at DEPTH
//  inst_valid  in   1      instruction valid
//  inst_ready  out  1      instruction ready
//  inst        in   16     [15:12] opcode, [11:0] operand
//  res_valid   out  1      result valid
//  res_ready   in   1      result accepted by consumer
//  res_data    out  DIM    result vector
//  res_last    out  1      end-of-stream marker, qualified by res_valid
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; R1, R2, fill word counter, fill address and fill_count cleared; state IDLE.
//  Reset: item memory not cleared. Reset mid-operation abandons the operation; no result is emitted.
//  FSM states: IDLE, LD_WAIT, OUT.
//  Transfer on an edge where valid & ready. inst_ready = (state==IDLE) & ~fill_en & ~wr_pending.
//  Opcodes, all executed on the accepting edge:
//   0 NOP  : no effect.
//   1 LOAD : mem_q <= mem[operand[AW-1:0]]; go to LD_WAIT.
//            Next edge: R2 <= mem_q, back to IDLE. Total 2 cycles; inst_ready=0 for one cycle.
//   2 PERM : R2 <= rotl(R2, k), k = operand[SW-1:0] mod DIM; bit i moves to (i+k) mod DIM; k=0 is identity.
//   3 XOR  : R2 <= R1 ^ R2.
//   4 MOVE : R1 <= R2.
//   5 STORE: res_data <= R2, res_valid <= 1, res_last <= 0; go to OUT.
//   6 LAST : res_data <= 0, res_valid <= 1, res_last <= 1; go to OUT.
//   7 CLR  : R1 <= 0, R2 <= 0.
//   8-15   : treated as NOP.
//  OUT: res_data, res_valid and res_last are held stable until res_ready.
//   On the accepting edge, res_valid and res_last drop to 0, res_data goes to 0, and state returns to IDLE.
//   res_ready with res_valid=0 is ignored.
//  Fill: each accepted word is stored into buffer slot wcnt and wcnt increments.
//   At wcnt == DIM/WORD-1 the buffer is complete: wcnt wraps to 0 and wr_pending is set.
//   On the next edge: mem[faddr] <= buffer, faddr++ (wraps at DEPTH), fill_count++ (saturates).
//   A pending write completes even if fill_en falls in the same cycle.
//   fill_en=0 resets wcnt, faddr and fill_count on the next edge.
//  A LOAD cannot collide with a write, because inst_ready=0 while fill_en or wr_pending is set.
//  Simultaneous inst_valid and fill_valid: fill wins; instruction stalls.
// TESTING (bench uses DIM=64, WORD=32, DEPTH=4)
//  1. Fill 0x00000001, 0x80000000; LOAD 0; STORE
//     -> res_data=64'h8000_0000_0000_0001; LOAD gives inst_ready low for exactly 1 cycle.
//  2. After 1: PERM 1; STORE -> 64'h0000_0000_0000_0003. PERM 64 (k=0) -> unchanged.
//  3. STORE with res_ready=0 for 5 cycles -> res_valid=1, data stable, inst_ready=0;
//     res_ready=1 -> handshake completes, next inst accepted the following cycle.
//  4. Fill 5 vectors -> vector 4 overwrites addr 0 (LOAD 0 returns it); fill_count saturates at 4.
//  5. LOAD a; MOVE; LOAD b; XOR; STORE -> a^b. Then LAST -> res_last=1, res_data=0. CLR; STORE -> 0.
//  6. rst during LD_WAIT and during a half-filled vector
//     -> all outputs 0, no result, next fill starts at addr 0 / word 0.

Source files
------------

// File: rtl/hv_core_param_if.sv
// Bus bundle for hv_core_param: random fill stream, instruction stream and result port.
interface hv_core_param_if #(
    parameter int unsigned DIM   = 1024,
    parameter int unsigned WORD  = 32,
    parameter int unsigned DEPTH = 512
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic            fill_en;
    logic            fill_valid;
    logic            fill_ready;
    logic [WORD-1:0] fill_data;
    logic [AW:0]     fill_count;
    logic            inst_valid;
    logic            inst_ready;
    logic [15:0]     inst;
    logic            res_valid;
    logic            res_ready;
    logic [DIM-1:0]  res_data;
    logic            res_last;
    logic            busy;

    modport master (
        output fill_en, fill_valid, fill_data, inst_valid, inst, res_ready,
        input  fill_ready, fill_count, inst_ready, res_valid, res_data, res_last, busy
    );

    modport slave (
        input  fill_en, fill_valid, fill_data, inst_valid, inst, res_ready,
        output fill_ready, fill_count, inst_ready, res_valid, res_data, res_last, busy
    );
endinterface

// File: rtl/hv_core_param.sv
// Hypervector compute core: item memory filled from a word stream, XOR bind, rotate permute,
// and a backpressured result port driven by a 16-bit instruction stream.
module hv_core_param #(
    parameter int unsigned DIM   = 1024,
    parameter int unsigned WORD  = 32,
    parameter int unsigned DEPTH = 512
) (
    input logic            clk,
    input logic            rst,
    hv_core_param_if.slave bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SW  = $clog2(DIM);
    localparam int unsigned NW  = DIM / WORD;
    localparam int unsigned WCW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [WCW-1:0] LastWord = WCW'(NW - 1);
    localparam logic [AW:0]    FillMax  = (AW + 1)'(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LD_WAIT = 2'd1;
    localparam logic [1:0] OUT     = 2'd2;

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_PERM  = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_MOVE  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_LAST  = 4'd6;
    localparam logic [3:0] OP_CLR   = 4'd7;

    logic [1:0]       state_q, state_d;
    logic [DIM-1:0]   r1_q, r1_d;
    logic [DIM-1:0]   r2_q, r2_d;
    logic [DIM-1:0]   res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             res_last_q, res_last_d;
    logic [DIM-1:0]   mem_q;
    logic [DIM-1:0]   mem [DEPTH];

    logic [DIM-1:0]   fbuf_q;
    logic [WCW-1:0]   wcnt_q;
    logic [AW-1:0]    faddr_q;
    logic [AW:0]      fcount_q;
    logic             wr_pending_q;

    logic             inst_fire;
    logic             fill_fire;
    logic [3:0]       opcode;
    logic [SW-1:0]    rot_k;
    logic [2*DIM-1:0] rot_dbl;

    assign opcode  = bus.inst[15:12];
    assign rot_k   = SW'(32'(bus.inst[SW-1:0]) % DIM);
    // Upper half of the doubled, left-shifted vector is the left rotation by rot_k.
    assign rot_dbl = {r2_q, r2_q} << rot_k;

    assign bus.fill_ready = bus.fill_en & ~rst;
    assign bus.inst_ready = (state_q == IDLE) & ~bus.fill_en & ~wr_pending_q & ~rst;
    assign inst_fire      = bus.inst_valid & bus.inst_ready;
    assign fill_fire      = bus.fill_valid & bus.fill_ready;

    assign bus.fill_count = fcount_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_last   = res_last_q;
    assign bus.busy       = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        case (state_q)
            IDLE: begin
                if (inst_fire) begin
                    case (opcode)
                        OP_LOAD:  state_d = LD_WAIT;
                        OP_PERM:  r2_d = rot_dbl[2*DIM-1:DIM];
                        OP_XOR:   r2_d = r1_q ^ r2_q;
                        OP_MOVE:  r1_d = r2_q;
                        OP_STORE: begin
                            res_data_d  = r2_q;
                            res_valid_d = 1'b1;
                            res_last_d  = 1'b0;
                            state_d     = OUT;
                        end
                        OP_LAST: begin
                            res_data_d  = '0;
                            res_valid_d = 1'b1;
                            res_last_d  = 1'b1;
                            state_d     = OUT;
                        end
                        OP_CLR: begin
                            r1_d = '0;
                            r2_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            LD_WAIT: begin
                r2_d    = mem_q;
                state_d = IDLE;
            end
            OUT: begin
                if (bus.res_ready) begin
                    res_data_d  = '0;
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r1_q        <= '0;
            r2_q        <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
        end
    end

    // Item memory has no reset; LOAD never overlaps a write since inst_ready blocks it.
    always_ff @(posedge clk) begin
        if (wr_pending_q && !rst) begin
            mem[faddr_q] <= fbuf_q;
        end
        if (inst_fire && opcode == OP_LOAD) begin
            mem_q <= mem[bus.inst[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (fill_fire) begin
            fbuf_q[wcnt_q*WORD +: WORD] <= bus.fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q       <= '0;
            faddr_q      <= '0;
            fcount_q     <= '0;
            wr_pending_q <= 1'b0;
        end else begin
            wr_pending_q <= 1'b0;
            if (fill_fire) begin
                if (wcnt_q == LastWord) begin
                    wcnt_q       <= '0;
                    wr_pending_q <= 1'b1;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end
            // A pending write still lands at faddr_q before the counters clear.
            if (!bus.fill_en) begin
                wcnt_q   <= '0;
                faddr_q  <= '0;
                fcount_q <= '0;
            end else if (wr_pending_q) begin
                faddr_q <= faddr_q + 1'b1;
                if (fcount_q != FillMax) begin
                    fcount_q <= fcount_q + 1'b1;
                end
            end
        end
    end
endmodule
